rv2t_fetch_realign: RTL
=======================

// Module: rv2t_fetch_realign
// PURPOSE
//  Instruction-fetch sequencer and realigner in front of the RVC expander/decoder.
//  - Issues word-aligned 32-bit fetches and buffers the returned halfwords.
//  - Splits the halfword stream into whole instructions (16-bit or 32-bit, any halfword alignment).
//  - Presents one instruction per valid/ready handshake, together with its PC.
//  - Handles redirects from branches, jumps and traps.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first PC after reset; must be halfword aligned
// PORTS
//  clk                  in   1   system clock
//  reset                in   1   asynchronous reset, active-high
//  redirect             in   1   flush and restart fetch at redirect_pc
//  redirect_pc          in   32  new PC; bit0 ignored
//  fetch_req            out  1   fetch request to instruction memory
//  fetch_addr           out  32  word address; bits[1:0] always 2'b00
//  fetch_gnt            in   1   request accepted this cycle
//  fetch_rvalid         in   1   read data valid; never in the same cycle as its gnt
//  fetch_rdata          in   32  read word, little-endian halfwords
//  instr_valid          out  1   instr_* outputs hold a complete instruction
//  instr_ready          in   1   consumer takes the instruction
//  instr_data           out  32  raw instruction; 16-bit form zero-extended to {16'h0,hw}
//  instr_pc             out  32  PC of instr_data
//  instr_is_compressed  out  1   instr_data[1:0] != 2'b11
//  instr_illegal        out  1   see CONFIGURATION
// BEHAVIOUR
//  - Reset (async) values:
//    - Queue empty, fetch_pc = RESET_PC & ~3, skip = RESET_PC[1], out_pc = RESET_PC, FSM = IDLE.
//    - fetch_req = 0, instr_valid = 0, instr_data = 0, instr_is_compressed = 0, instr_illegal = 0.
//  - Halfword queue: 4 entries, count 0..4. q0 is the head.
//  - Fetch FSM, at most one outstanding fetch:
//    - IDLE -> WAIT_GNT when registered count <= 2 and no redirect. fetch_req = 1, fetch_addr = fetch_pc.
//    - WAIT_GNT: hold fetch_req and fetch_addr until fetch_gnt, then -> WAIT_DATA.
//    - WAIT_DATA -> IDLE on fetch_rvalid:
//      - Push lo then hi halfword; if skip = 1, push hi only.
//      - fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); skip = 0.
//    - Fetch latency: the earliest fetch_req is the first cycle after reset deasserts.
//  - Output, combinational from registered queue state:
//    - q0[1:0] != 2'b11: 16-bit; valid when count >= 1.
//    - q0[1:0] == 2'b11: 32-bit; valid when count >= 2. A 32-bit instruction straddling words waits with valid = 0.
//    - instr_pc = out_pc.
//  - Consume on instr_valid & instr_ready:
//    - Pop 1 or 2 entries; out_pc += 2 or 4.
//    - Push and pop in the same cycle are both applied: count = count - pop + push.
//    - Overflow is impossible: issue requires count <= 2.
//  - instr_ready = 0: instr_* stay stable; the queue fills to at most 4; no new fetch issues while count > 2.
//  - Redirect (highest priority; takes effect the next cycle):
//    - Queue cleared; instr_valid = 0 the next cycle.
//    - out_pc = redirect_pc & ~1; fetch_pc = redirect_pc & ~3; skip = redirect_pc[1].
//    - An instr handshake in the redirect cycle is ignored: no pop, no PC advance.
//    - In IDLE: next cycle stays in IDLE and issues per normal rules.
//    - In WAIT_GNT: stay in WAIT_GNT; fetch_addr updates to the new fetch_pc the next cycle.
//    - In WAIT_DATA: set discard and stay in WAIT_DATA. The next rvalid is dropped, then clear discard -> IDLE.
//    - Redirect in the same cycle as rvalid: that data is dropped and the FSM returns to IDLE.
//  - Reset mid-operation: all state returns to reset values immediately. A late fetch_rvalid with FSM in IDLE is ignored.
// CONFIGURATION
//  - RV2T_RVC_EN defined:
//    - 16-bit instructions are realigned as above.
//    - instr_illegal is tied to 0; the downstream expander flags bad encodings.
//  - RV2T_RVC_EN undefined:
//    - Every instruction takes 2 halfwords (valid when count >= 2); out_pc += 4.
//    - instr_is_compressed is tied to 0.
//    - instr_illegal = instr_valid & (q0[1:0] != 2'b11).
//    - redirect_pc[1] is still honoured for skip, so misaligned targets surface as illegal.
// TESTING
//  1. RESET_PC = 0; word@0 = 32'h0000_0013
//     -> fetch_addr = 0; instr_data = 32'h0000_0013, instr_pc = 0, is_compressed = 0.
//  2. Word@0 = 32'h4501_4505 (RVC_EN)
//     -> 32'h0000_4505 @ pc 0, then 32'h0000_4501 @ pc 2, both is_compressed = 1.
//  3. Straddle: word@0 = 32'h0013_4505, word@4 = 32'hxxxx_0000
//     -> 32'h0000_4505 @ pc 0; then 32'h0000_0013 @ pc 2, valid only after word@4 arrives.
//  4. Redirect to 32'h0000_0102; word@100 = 32'h0013_4505
//     -> fetch_addr = 32'h100; low half dropped; first instr is 32-bit, pc 32'h102, upper half from word@104.
//  5. Redirect to 32'h200 during WAIT_DATA for 32'h8
//     -> stale rvalid dropped, no instr_valid; next fetch_addr = 32'h200.
//  6. instr_ready = 0 for 10 cycles over compressed code
//     -> count reaches 4, fetch_req stays 0, instr_data/instr_pc stable; release drains in order.
//  7. RVC_EN undefined; word@0 = 32'h4501_4505
//     -> instr_illegal = 1, instr_pc = 0, then pc 4.

Source files
------------

// File: rtl/rv2t_fetch_realign_if.sv
// Fetch-unit bundle: redirect, instruction-memory and instruction-out signals.
// master = fetch realigner, slave = environment (memory, consumer, redirect source).
interface rv2t_fetch_realign_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;
  logic        instr_illegal;

  modport master (
    input  redirect, redirect_pc,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    input  instr_ready,
    output fetch_req, fetch_addr,
    output instr_valid, instr_data, instr_pc,
    output instr_is_compressed, instr_illegal
  );

  modport slave (
    output redirect, redirect_pc,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    output instr_ready,
    input  fetch_req, fetch_addr,
    input  instr_valid, instr_data, instr_pc,
    input  instr_is_compressed, instr_illegal
  );
endinterface

// File: rtl/rv2t_fetch_realign.sv
// Word fetch sequencer + halfword realigner feeding the RVC expander.
// Optional: define RV2T_RVC_EN to realign 16-bit instructions.
module rv2t_fetch_realign #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  rv2t_fetch_realign_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_DATA
  } fsm_t;

  fsm_t        state;
  logic [15:0] q [4];
  logic [15:0] q_n [4];
  logic [2:0]  count;
  logic [2:0]  count_n;
  logic [2:0]  cnt_after;
  logic [31:0] fetch_pc;
  logic [31:0] out_pc;
  logic        skip;
  logic        discard;

  logic        is32;
  logic [2:0]  need;
  logic        valid;
  logic        hs;
  logic [2:0]  pop;
  logic        push_ok;
  logic [2:0]  push_n;

`ifdef RV2T_RVC_EN
  assign is32 = (q[0][1:0] == 2'b11);
`else
  assign is32 = 1'b1;
`endif

  assign need  = is32 ? 3'd2 : 3'd1;
  assign valid = (count >= need);

  assign hs  = valid & bus.instr_ready & ~bus.redirect;
  assign pop = hs ? need : 3'd0;

  assign push_ok = (state == WAIT_DATA) & bus.fetch_rvalid
                 & ~discard & ~bus.redirect;
  assign push_n  = push_ok ? (skip ? 3'd1 : 3'd2) : 3'd0;

  assign cnt_after = count - pop;
  assign count_n   = cnt_after + push_n;

  assign bus.fetch_req   = (state == WAIT_GNT);
  assign bus.fetch_addr  = fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instr_pc    = out_pc;
  assign bus.instr_data  = !valid ? 32'h0 :
                           is32   ? {q[1], q[0]} :
                                    {16'h0, q[0]};

`ifdef RV2T_RVC_EN
  assign bus.instr_is_compressed = valid & ~is32;
  assign bus.instr_illegal       = 1'b0;
`else
  assign bus.instr_is_compressed = 1'b0;
  assign bus.instr_illegal       = valid & (q[0][1:0] != 2'b11);
`endif

  // Next queue contents: drop popped head entries, then append the fetched halfwords.
  always_comb begin
    q_n = q;
    case (pop)
      3'd1: begin
        q_n[0] = q[1];
        q_n[1] = q[2];
        q_n[2] = q[3];
        q_n[3] = 16'h0;
      end
      3'd2: begin
        q_n[0] = q[2];
        q_n[1] = q[3];
        q_n[2] = 16'h0;
        q_n[3] = 16'h0;
      end
      default: ;
    endcase
    if (push_ok) begin
      if (skip) begin
        q_n[cnt_after[1:0]] = bus.fetch_rdata[31:16];
      end else begin
        q_n[cnt_after[1:0]]        = bus.fetch_rdata[15:0];
        q_n[cnt_after[1:0] + 2'd1] = bus.fetch_rdata[31:16];
      end
    end
  end

  // Queue, PC tracking and the one-outstanding-request fetch FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '{default: 16'h0};
      count    <= 3'd0;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      skip     <= RESET_PC[1];
      out_pc   <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      q <= q_n;
      if (bus.redirect) begin
        count    <= 3'd0;
        out_pc   <= {bus.redirect_pc[31:1], 1'b0};
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        skip     <= bus.redirect_pc[1];
      end else begin
        count  <= count_n;
        out_pc <= out_pc + {28'h0, pop, 1'b0};
        if (push_ok) begin
          fetch_pc <= fetch_pc + 32'd4;
          skip     <= 1'b0;
        end
      end

      unique case (state)
        IDLE: begin
          if (!bus.redirect && count <= 3'd2) state <= WAIT_GNT;
        end
        WAIT_GNT: begin
          // A grant coinciding with a redirect fetched the old address: drop its data.
          if (bus.fetch_gnt) begin
            state   <= WAIT_DATA;
            discard <= bus.redirect;
          end
        end
        WAIT_DATA: begin
          if (bus.fetch_rvalid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (bus.redirect) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
